addsub_arbiter: RTL and testbench

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_arbiter.sv | 133 +++++++++++++
 tb/tb_addsub_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter in front of one shared 4-bit adder-subtractor.
// Each accepted request takes three cycles (latch, compute, respond) and ends in a one-cycle gnt pulse.
//
// state | meaning
// IDLE  | waiting for a request; winner's operands latched on the accepting edge
// EXEC  | latched operands pass through the adder; S/Cout/V registered
// RESP  | gnt of the owner pulses; round-robin pointer moves past the owner
module addsub_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [3:0] A0,
    input  logic [3:0] B0,
    input  logic       M0,
    input  logic       req1,
    input  logic [3:0] A1,
    input  logic [3:0] B1,
    input  logic       M1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [3:0] S,
    output logic       Cout,
    output logic       V,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic       m_q, m_d;
    logic       owner_q, owner_d;
    logic       prio1_q, prio1_d;
    logic [3:0] s_q, s_d;
    logic       cout_q, cout_d;
    logic       v_q, v_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;

    logic       win1;
    logic [3:0] b_eff;
    logic [4:0] sum_full;
    logic       carry3;

    // Requester 1 wins when it is alone, or when both ask and the pointer favours it.
    assign win1 = req1 & (~req0 | prio1_q);

    // Subtract is A + ~B + 1; the +1 enters as the adder's carry-in.
    assign b_eff    = m_q ? ~b_q : b_q;
    assign sum_full = {1'b0, a_q} + {1'b0, b_eff} + {4'd0, m_q};
    // Carry into bit 3 recovered from bit 3's sum and operand bits.
    assign carry3   = a_q[3] ^ b_eff[3] ^ sum_full[3];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        owner_d = owner_q;
        prio1_d = prio1_q;
        s_d     = s_q;
        cout_d  = cout_q;
        v_d     = v_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    owner_d = win1;
                    a_d     = win1 ? A1 : A0;
                    b_d     = win1 ? B1 : B0;
                    m_d     = win1 ? M1 : M0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                s_d     = sum_full[3:0];
                cout_d  = sum_full[4];
                v_d     = carry3 ^ sum_full[4];
                gnt0_d  = ~owner_q;
                gnt1_d  = owner_q;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                prio1_d = ~owner_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            m_q     <= 1'b0;
            owner_q <= 1'b0;
            prio1_q <= 1'b0;
            s_q     <= 4'd0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            owner_q <= owner_d;
            prio1_q <= prio1_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
        end
    end

    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;
    assign S    = s_q;
    assign Cout = cout_q;
    assign V    = v_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed vector table, hand-written reset/arbitration
// sequences, and a randomized run against a transaction-level reference model.
module tb_addsub_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, M0, M1;
    logic [3:0] A0, B0, A1, B1;
    logic       gnt0, gnt1, Cout, V, busy;
    logic [3:0] S;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    addsub_arbiter dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req0 (req0),
        .A0   (A0),
        .B0   (B0),
        .M0   (M0),
        .req1 (req1),
        .A1   (A1),
        .B1   (B1),
        .M1   (M1),
        .gnt0 (gnt0),
        .gnt1 (gnt1),
        .S    (S),
        .Cout (Cout),
        .V    (V),
        .busy (busy)
    );

    typedef struct {
        bit         side;
        logic [3:0] a;
        logic [3:0] b;
        bit         m;
        logic [3:0] s;
        bit         c;
        bit         v;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string pfx, input bit g0, input bit g1, input logic [3:0] s,
                             input bit c, input bit v, input bit b);
        chk({pfx, ".gnt0"}, {7'd0, gnt0}, {7'd0, g0});
        chk({pfx, ".gnt1"}, {7'd0, gnt1}, {7'd0, g1});
        chk({pfx, ".S"},    {4'd0, S},    {4'd0, s});
        chk({pfx, ".Cout"}, {7'd0, Cout}, {7'd0, c});
        chk({pfx, ".V"},    {7'd0, V},    {7'd0, v});
        chk({pfx, ".busy"}, {7'd0, busy}, {7'd0, b});
    endtask

    // Reference arithmetic from integer rules: wrap mod 16, unsigned carry/no-borrow, signed range.
    function automatic void ref_calc(input logic [3:0] a, input logic [3:0] b, input logic m,
                                     output logic [3:0] s, output logic c, output logic v);
        int ai, bi, sa, sb, r;
        ai = int'(a);
        bi = int'(b);
        sa = (ai > 7) ? ai - 16 : ai;
        sb = (bi > 7) ? bi - 16 : bi;
        if (m) begin
            s = 4'((ai - bi + 16) % 16);
            c = (ai >= bi);
            r = sa - sb;
        end else begin
            s = 4'((ai + bi) % 16);
            c = ((ai + bi) > 15);
            r = sa + sb;
        end
        v = (r > 7) || (r < -8);
    endfunction

    task automatic randomize_ops;
        A0 = 4'($urandom_range(0, 15));
        B0 = 4'($urandom_range(0, 15));
        M0 = 1'($urandom_range(0, 1));
        A1 = 4'($urandom_range(0, 15));
        B1 = 4'($urandom_range(0, 15));
        M1 = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] ps, es;
        logic       pc, pv, ec, ev;
        int         n, e0, free_edge, edge_n;
        bit         prefer1, win, g, dut_side;

        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        randomize_ops();

        vecs[0] = '{1'b0, 4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 4'h5, 4'h3, 1'b1, 4'h2, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 4'h8, 4'h1, 1'b1, 4'h7, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 4'h0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};
        vecs[8] = '{1'b1, 4'h0, 4'h1, 1'b1, 4'hF, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 4'h7, 4'h8, 1'b1, 4'hF, 1'b0, 1'b1};

        // Reset dominates even with both requests high.
        tick;
        tick;
        check_out("reset", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        rst_n = 1'b1;

        // Directed single-requester vectors; operands scrambled and req dropped after latching.
        ps = 4'h0; pc = 1'b0; pv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            randomize_ops();
            if (vecs[i].side) begin
                req1 = 1'b1; A1 = vecs[i].a; B1 = vecs[i].b; M1 = vecs[i].m;
            end else begin
                req0 = 1'b1; A0 = vecs[i].a; B0 = vecs[i].b; M0 = vecs[i].m;
            end
            tick;
            check_out($sformatf("vec%0d.exec", i), 1'b0, 1'b0, ps, pc, pv, 1'b1);
            req0 = 1'b0; req1 = 1'b0;
            randomize_ops();
            tick;
            check_out($sformatf("vec%0d.resp", i), !vecs[i].side, vecs[i].side,
                      vecs[i].s, vecs[i].c, vecs[i].v, 1'b1);
            tick;
            ps = vecs[i].s; pc = vecs[i].c; pv = vecs[i].v;
            check_out($sformatf("vec%0d.idle", i), 1'b0, 1'b0, ps, pc, pv, 1'b0);
        end

        // Both requests held from reset: alternating grants, one every 3 cycles.
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        A0 = 4'h3; B0 = 4'h4; M0 = 1'b0;
        A1 = 4'h9; B1 = 4'h2; M1 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick;
            g = (k % 3 == 2);
            chk($sformatf("rr%0d.gnt0", k), {7'd0, gnt0}, {7'd0, g && ((k / 3) % 2 == 0)});
            chk($sformatf("rr%0d.gnt1", k), {7'd0, gnt1}, {7'd0, g && ((k / 3) % 2 == 1)});
            if (g) begin
                if ((k / 3) % 2 == 0) ref_calc(A0, B0, M0, es, ec, ev);
                else                  ref_calc(A1, B1, M1, es, ec, ev);
                chk($sformatf("rr%0d.S", k), {4'd0, S}, {4'd0, es});
                chk($sformatf("rr%0d.V", k), {7'd0, V}, {7'd0, ev});
            end
        end
        req0 = 1'b0; req1 = 1'b0;

        // Operand change after latch, then reset during a later EXEC.
        do_reset();
        req0 = 1'b1; A0 = 4'h2; B0 = 4'h3; M0 = 1'b0;
        tick;
        req0 = 1'b0; A0 = 4'hF; B0 = 4'hF; M0 = 1'b1;
        tick;
        check_out("inflight.resp", 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1);
        tick;
        req1 = 1'b1; A1 = 4'h6; B1 = 4'h1; M1 = 1'b0;
        tick;
        chk("abort.exec.busy", {7'd0, busy}, 8'd1);
        rst_n = 1'b0; req1 = 1'b0;
        tick;
        check_out("abort.reset", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            check_out($sformatf("abort.after%0d", k), 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        end
        // Pointer must be back to requester-0 priority after that reset.
        req0 = 1'b1; req1 = 1'b1;
        A0 = 4'h1; B0 = 4'h2; M0 = 1'b0;
        tick;
        req0 = 1'b0; req1 = 1'b0;
        tick;
        check_out("ptr_reset", 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b1);
        tick;

        // Randomized traffic against the transaction-level model.
        do_reset();
        n = 0; e0 = -10; free_edge = 1; prefer1 = 1'b0; dut_side = 1'b0;
        ps = 4'h0; pc = 1'b0; pv = 1'b0;
        es = 4'h0; ec = 1'b0; ev = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            req0 = ($urandom_range(0, 2) != 0);
            req1 = ($urandom_range(0, 2) != 0);
            randomize_ops();
            edge_n = n + 1;
            if (edge_n >= free_edge && (req0 || req1)) begin
                win = (req0 && req1) ? prefer1 : req1;
                if (win) ref_calc(A1, B1, M1, es, ec, ev);
                else     ref_calc(A0, B0, M0, es, ec, ev);
                dut_side  = win;
                prefer1   = !win;
                e0        = edge_n;
                free_edge = edge_n + 3;
            end
            tick;
            n = edge_n;
            g = (n == e0 + 1);
            if (g) begin
                ps = es; pc = ec; pv = ev;
            end
            check_out($sformatf("rnd%0d", cyc), g && !dut_side, g && dut_side, ps, pc, pv,
                      (n == e0) || (n == e0 + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
